// File: rtl/pipeline_flow_ctrl.sv
// rtl/pipeline_flow_ctrl.sv - flow control around a 3-stage global-stall pipeline
// Feeds the pipeline from a valid/ready source, sequences flushes, and buffers results in a FWFT FIFO.
module pipeline_flow_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic                       flush_req,
  output logic [DATA_W-1:0]          pipe_inputs,
  output logic                       pipe_in_valid,
  output logic                       pipe_flush,
  output logic                       pipe_stall,
  input  logic [DATA_W-1:0]          pipe_outputs,
  input  logic                       pipe_out_valid,
  input  logic                       pipe_out_flush,
  output logic [DATA_W-1:0]          dst_data,
  output logic                       dst_valid,
  input  logic                       dst_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              stall_q;
  logic              capture, push, pop, full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pipe_flush = 1'b0;
    case (state)
      IDLE:    if (flush_req) state_nxt = FLUSH;
      FLUSH: begin
        pipe_flush = 1'b1;
        state_nxt  = DRAIN;
      end
      DRAIN:   if (pipe_out_flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall leaves 4 free slots: 3 in-flight items plus the one already at the pipe output.
  assign pipe_stall    = (state == IDLE) && (fifo_count >= CNT_W'(DEPTH - 4));
  assign src_ready     = (state == IDLE) && !pipe_stall;
  assign pipe_in_valid = src_valid && src_ready && reset;
  assign pipe_inputs   = src_data;

  // stall_q blocks re-capture of an output the pipeline is holding during a stall.
  assign capture   = pipe_out_valid && !stall_q && (state != DRAIN);
  assign full      = (fifo_count == CNT_W'(DEPTH));
  assign dst_valid = (fifo_count != '0);
  assign pop       = dst_valid && dst_ready;
  assign push      = capture && (!full || pop);
  assign dst_data  = reset ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_outputs;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      stall_q      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      stall_q <= pipe_stall;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (capture && full && !pop) err_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/pipeline_flow_ctrl.md
PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, the item width.
- REQ-002 SHALL have parameter DEPTH, default 8, the output FIFO depth (power of 2, minimum 8).
- REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
- REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low.
- REQ-005 SHALL have ports src_data input DATA_W, src_valid input 1, src_ready output 1: upstream valid/ready source.
- REQ-006 SHALL have port flush_req, input, 1, a level request to flush the pipeline.
- REQ-007 SHALL have ports pipe_inputs output DATA_W, pipe_in_valid output 1, pipe_flush output 1, pipe_stall output 1: drive the 3-stage global-stall pipeline.
- REQ-008 SHALL have ports pipe_outputs input DATA_W, pipe_out_valid input 1, pipe_out_flush input 1: pipeline results and delayed flush marker.
- REQ-009 SHALL have ports dst_data output DATA_W, dst_valid output 1, dst_ready input 1: downstream valid/ready sink.
- REQ-010 SHALL have ports fifo_count output clog2(DEPTH)+1, the FIFO occupancy, and err_overflow output 1, a sticky error flag.

Function
- REQ-011 SHALL implement an FSM with states IDLE, FLUSH, DRAIN.
- REQ-012 SHALL move IDLE->FLUSH on a cycle with flush_req=1, FLUSH->DRAIN unconditionally, and DRAIN->IDLE after a cycle with pipe_out_flush=1.
- REQ-013 SHALL ignore flush_req in FLUSH and DRAIN; a flush_req still high on return to IDLE starts a new flush.
- REQ-014 SHALL drive pipe_flush=1 only in FLUSH (exactly one cycle per flush).
- REQ-015 SHALL drive pipe_stall = (state==IDLE) and (fifo_count >= DEPTH-4), combinationally.
- REQ-016 SHALL drive src_ready = (state==IDLE) and not pipe_stall.
- REQ-017 SHALL drive pipe_in_valid = src_valid and src_ready, and pipe_inputs = src_data; one item is transferred per cycle in which both are high.
- REQ-018 SHALL hold a registered copy stall_q of pipe_stall (reset 0).
- REQ-019 SHALL capture pipe_outputs into the FIFO when pipe_out_valid=1, stall_q=0, and state!=DRAIN; a held output during a stall is captured once only.
- REQ-020 SHALL discard every pipe_out_valid item presented in DRAIN, including the cycle in which pipe_out_flush=1.
- REQ-021 SHALL present FIFO data first-word-fall-through: dst_valid = (fifo_count != 0), dst_data = head entry.
- REQ-022 SHALL pop the head when dst_valid and dst_ready are both 1.
- REQ-023 SHALL leave fifo_count unchanged on a simultaneous push and pop; this also holds when full.
- REQ-024 SHALL wrap read and write pointers modulo DEPTH.
- REQ-025 SHALL not clear FIFO contents on a flush; only items not yet captured are lost.
- REQ-026 SHALL drop a push while fifo_count==DEPTH and no pop occurs, and set err_overflow=1 until reset.
- REQ-027 SHALL, by the threshold of REQ-015, never reach the condition of REQ-026 under legal pipeline behaviour.

Reset
- REQ-028 SHALL, while reset=0, force state=IDLE, fifo_count=0, pointers=0, stall_q=0, err_overflow=0.
- REQ-029 SHALL, while reset=0, hold outputs pipe_flush=0, pipe_stall=0, pipe_in_valid=0 (src_valid ignored), dst_valid=0, src_ready=1, dst_data=0.
- REQ-030 SHALL abandon any in-progress FLUSH/DRAIN and discard FIFO contents on reset assertion mid-operation.

Verification
- REQ-031 Streaming: src sends 0x1..0x10 back-to-back, dst_ready=1 -> dst gets 0x1..0x10 in order, 3-cycle pipe latency plus 0 FIFO latency, no stall, fifo_count <= 1.
- REQ-032 Backpressure: dst_ready=0, 10 items offered -> pipe_stall rises at fifo_count=4, count peaks <= 6, err_overflow=0; release dst_ready -> all 10 items delivered exactly once, in order.
- REQ-033 Stall hold: pipeline holds 0xAA on pipe_outputs for 5 stalled cycles -> exactly one FIFO entry 0xAA.
- REQ-034 Flush: flush_req pulsed at cycle t with 3 items in flight -> pipe_flush=1 at t+1, src_ready=0 t+1..t+4, in-flight items dropped, IDLE at t+5, FIFO entries captured before t+2 retained.
- REQ-035 Simultaneous push/pop at fifo_count=DEPTH -> count stays DEPTH, err_overflow=0; forced push with no pop at full -> err_overflow=1 and sticky.
- REQ-036 Reset asserted during DRAIN with fifo_count=3 -> state IDLE, fifo_count=0, dst_valid=0, src_ready=1 immediately (asynchronous).
